stim_misr_ctrl: RTL and testbench
=================================

STIM_MISR_CTRL -- requirements
Module: stim_misr_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 4: stimulus width, 1..16.
REQ-002 SHALL have parameter PIPE_DEPTH, default 2: register stages between stim and resp in the subcircuit under test, 1..8.
REQ-003 SHALL have port I1470_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port I1477_rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: run request, sampled in IDLE or DONE only.
REQ-006 SHALL have port seed, input, 16: LFSR seed, captured when start is accepted.
REQ-007 SHALL have port num_pat, input, 16: pattern count, captured when start is accepted.
REQ-008 SHALL have port stim, output, PAT_W: stimulus to the subcircuit; equals lfsr[PAT_W-1:0].
REQ-009 SHALL have port stim_valid, output, 1: high in every RUN cycle only.
REQ-010 SHALL have port resp, input, 1: single-bit response of the subcircuit.
REQ-011 SHALL have port sig, output, 16: MISR signature.
REQ-012 SHALL have port busy, output, 1: high in RUN or FLUSH.
REQ-013 SHALL have port done, output, 1: high while in DONE (a level, not a pulse).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FLUSH, DONE.
REQ-015 start high in IDLE/DONE -> next RUN; lfsr<=seed (0x0000 replaced by 0x0001); sig<=0; pattern counter<=num_pat; done<=0.
REQ-016 SHALL ignore start in RUN and FLUSH.
REQ-017 num_pat=0 with start accepted -> next state DONE directly, sig=0x0000, stim_valid never asserted.
REQ-018 RUN lasts exactly num_pat cycles; the first RUN cycle presents stim=seed[PAT_W-1:0]; each later RUN cycle advances the LFSR once.
REQ-019 LFSR SHALL be 16-bit Fibonacci, x^16+x^14+x^13+x^11+1: next={q[14:0], q[15]^q[13]^q[12]^q[10]}.
REQ-020 RUN -> FLUSH after the last pattern; FLUSH lasts PIPE_DEPTH cycles; stim holds its last value; stim_valid=0.
REQ-021 FLUSH -> DONE; done asserts exactly num_pat+PIPE_DEPTH+1 cycles after the cycle start was sampled.
REQ-022 Capture enable SHALL be stim_valid delayed by PIPE_DEPTH registers; MISR updates only when enable=1.
REQ-023 MISR update SHALL be sig<={sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]^resp}.
REQ-024 sig SHALL hold its value in DONE and IDLE until the next accepted start.
REQ-025 Pattern counter SHALL be 16-bit; num_pat=0xFFFF SHALL run 65535 patterns without wrap error.

Reset
REQ-026 I1477_rst high SHALL immediately force IDLE, stim=0, stim_valid=0, sig=0x0000, busy=0, done=0, lfsr=0x0001, delay line cleared.
REQ-027 Reset during RUN/FLUSH SHALL abort the run with no residual capture after release.
REQ-028 After reset release, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-029 With STIM_MISR_GOLDEN_CMP_EN defined: add input golden (16) and output pass (1); pass=1 only in DONE when sig==golden, else 0; pass resets to 0.
REQ-030 Without STIM_MISR_GOLDEN_CMP_EN: golden and pass ports absent; all other behaviour identical.

Verification
REQ-031 seed=0x0001, num_pat=5, PAT_W=4 -> stim 1,2,4,8,0 on RUN cycles 1..5; stim_valid high for exactly 5 cycles.
REQ-032 resp=0 constant, num_pat=8 -> sig=0x0000, done high at cycle 11 (PIPE_DEPTH=2).
REQ-033 resp=1 constant, num_pat=2 -> sig=0x0003 at DONE; num_pat=1 -> sig=0x0001.
REQ-034 seed=0x0000, num_pat=1 -> stim=1 (seed substituted); num_pat=0 -> done high 1 cycle after start, sig=0x0000.
REQ-035 Assert reset in cycle 3 of RUN -> all outputs at reset values same cycle; start pulse in FLUSH -> ignored, run completes normally.
REQ-036 With STIM_MISR_GOLDEN_CMP_EN, golden=0x0003, resp=1, num_pat=2 -> pass=1 in DONE; golden=0x0004 -> pass=0.

Source files
------------

// File: rtl/stim_misr_ctrl.sv
// stim_misr_ctrl: LFSR stimulus generator and MISR response compactor
// for a pipelined subcircuit under test.
// A run applies num_pat patterns and then waits PIPE_DEPTH flush cycles.
// Each response is folded into a 16-bit signature exactly PIPE_DEPTH
// cycles after its stimulus was presented.
// Optional feature: define STIM_MISR_GOLDEN_CMP_EN to add the golden input
// and the pass output. pass compares the final signature against golden.
module stim_misr_ctrl #(
  parameter int PAT_W      = 4,  // stimulus width, 1..16
  parameter int PIPE_DEPTH = 2   // pipeline stages in the subcircuit, 1..8
) (
  input  logic              I1470_clk,
  input  logic              I1477_rst,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic [15:0]       num_pat,
  output logic [PAT_W-1:0]  stim,
  output logic              stim_valid,
  input  logic              resp,
  output logic [15:0]       sig,
  output logic              busy,
  output logic              done
`ifdef STIM_MISR_GOLDEN_CMP_EN
  ,
  input  logic [15:0]       golden,
  output logic              pass
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  // Both polynomials share the tap set x^16+x^14+x^13+x^11 (bits 15,13,12,10).
  localparam logic [3:0] FLUSH_LAST = 4'(PIPE_DEPTH - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [15:0]           r_lfsr;
  logic [15:0]           r_pat_cnt;
  logic [3:0]            r_flush_cnt;
  logic [PIPE_DEPTH-1:0] r_vld_dly;
  logic [15:0]           r_sig;
  logic                  w_accept;
  logic                  w_advance;
  logic                  w_cap_en;
  logic                  w_lfsr_fb;
  logic                  w_misr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_misr_fb = r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10] ^ resp;
  assign w_cap_en  = r_vld_dly[PIPE_DEPTH-1];
  assign sig       = r_sig;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments. This makes
  // all registers update together from values sampled before the edge.
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // Next-state decode and state-derived outputs.
  // NOTE: every signal written here gets a default first. A path that left a
  // signal unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    stim_valid   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    // stim reads zero until the first run has loaded the LFSR.
    stim         = (r_state == S_IDLE) ? '0 : r_lfsr[PAT_W-1:0];
    unique case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = (num_pat == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        stim_valid = 1'b1;
        busy       = 1'b1;
        // The LFSR does not advance on the last pattern, so stim keeps that pattern through FLUSH.
        if (r_pat_cnt == 16'd1) w_next_state = S_FLUSH;
        else                    w_advance    = 1'b1;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (r_flush_cnt == 4'd0) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // LFSR and pattern counter: load on an accepted start, step once per non-final RUN cycle.
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      r_lfsr    <= 16'h0001;
      r_pat_cnt <= 16'd0;
    end else if (w_accept) begin
      // An all-zero seed would lock the LFSR, so it is replaced by 0x0001.
      r_lfsr    <= (seed == 16'd0) ? 16'h0001 : seed;
      r_pat_cnt <= num_pat;
    end else if (w_advance) begin
      r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
      r_pat_cnt <= r_pat_cnt - 16'd1;
    end
  end

  // Flush counter: preset during RUN, counts down to zero across FLUSH.
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst)                                    r_flush_cnt <= 4'd0;
    else if (r_state == S_RUN)                        r_flush_cnt <= FLUSH_LAST;
    else if (r_state == S_FLUSH && r_flush_cnt != 0)  r_flush_cnt <= r_flush_cnt - 4'd1;
  end

  // Capture-enable delay line that matches the subcircuit's pipeline latency.
  // NOTE: this shift register is reset on purpose. A reset during a run must
  // leave no stale enable bits that could corrupt the next signature.
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      r_vld_dly <= '0;
    end else begin
      r_vld_dly[0] <= stim_valid;
      for (int i = 1; i < PIPE_DEPTH; i++) r_vld_dly[i] <= r_vld_dly[i-1];
    end
  end

  // MISR: cleared on an accepted start, folds resp in only when the delayed enable is high.
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst)     r_sig <= 16'h0000;
    else if (w_accept) r_sig <= 16'h0000;
    else if (w_cap_en) r_sig <= {r_sig[14:0], w_misr_fb};
  end

`ifdef STIM_MISR_GOLDEN_CMP_EN
  // Golden compare: pass is valid only while the final signature is held in DONE.
  assign pass = (r_state == S_DONE) && (r_sig == golden);
`endif

endmodule

// File: tb/tb_stim_misr_ctrl.sv
// tb_stim_misr_ctrl: directed and randomized runs of stim_misr_ctrl.
// The DUT is compared against a reference model of the LFSR and MISR.
// Define STIM_MISR_GOLDEN_CMP_EN to also exercise the golden compare.
module tb_stim_misr_ctrl;
  localparam int PAT_W      = 4;
  localparam int PIPE_DEPTH = 2;
  localparam logic [15:0] TAPS = 16'hB400;  // bits 15,13,12,10

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       seed = 16'h0000;
  logic [15:0]       num_pat = 16'h0000;
  logic              resp = 1'b0;
  logic [PAT_W-1:0]  stim;
  logic              stim_valid;
  logic [15:0]       sig;
  logic              busy;
  logic              done;
`ifdef STIM_MISR_GOLDEN_CMP_EN
  logic [15:0]       golden = 16'h0000;
  logic              pass;
`endif

  int n_vec = 0;
  int n_mis = 0;

  stim_misr_ctrl #(.PAT_W(PAT_W), .PIPE_DEPTH(PIPE_DEPTH)) dut (
    .I1470_clk  (clk),
    .I1477_rst  (rst),
    .start      (start),
    .seed       (seed),
    .num_pat    (num_pat),
    .stim       (stim),
    .stim_valid (stim_valid),
    .resp       (resp),
    .sig        (sig),
    .busy       (busy),
    .done       (done)
`ifdef STIM_MISR_GOLDEN_CMP_EN
    ,
    .golden     (golden),
    .pass       (pass)
`endif
  );

  always #5 clk = ~clk;

  // Shift left, new LSB = parity of the tapped bits (xor resp for the MISR).
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return (q << 1) | {15'd0, ^(q & TAPS)};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic r);
    return (s << 1) | {15'd0, (^(s & TAPS)) ^ r};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_resp(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom());
  endfunction

  // One complete run. mode: 0 = resp always 0, 1 = resp always 1, 2 = random.
  // Outside the capture window resp carries noise that must not be captured.
  task automatic run_test(input logic [15:0] s, input int n, input int mode,
                          input bit flush_poke, input logic [15:0] gold);
    logic [15:0] q;
    logic [15:0] exp_sig;
    logic [3:0]  last_stim;
    logic [3:0]  e_stim[$];
    logic        r_tab[$];
    int          done_cyc;

    q         = (s == 16'd0) ? 16'h0001 : s;
    last_stim = q[3:0];
    for (int j = 0; j < n; j++) begin
      e_stim.push_back(q[3:0]);
      last_stim = q[3:0];
      q = lfsr_next(q);
    end
    exp_sig = 16'h0000;
    for (int j = 0; j < n; j++) begin
      r_tab.push_back(pick_resp(mode));
      exp_sig = misr_next(exp_sig, r_tab[j]);
    end
    done_cyc = (n == 0) ? 1 : n + PIPE_DEPTH + 1;

    seed    = s;
    num_pat = 16'(n);
    start   = 1'b1;
    resp    = pick_resp(mode);
`ifdef STIM_MISR_GOLDEN_CMP_EN
    golden  = gold;
`endif
    tick();
    start = 1'b0;

    for (int k = 1; k <= done_cyc; k++) begin
      if (k == done_cyc) begin
        check("done_lvl", {15'd0, done}, 16'd1);
        check("done_busy", {15'd0, busy}, 16'd0);
        check("done_vld", {15'd0, stim_valid}, 16'd0);
        check("done_stim", {12'd0, stim}, {12'd0, last_stim});
        check("done_sig", sig, exp_sig);
`ifdef STIM_MISR_GOLDEN_CMP_EN
        check("done_pass", {15'd0, pass}, {15'd0, exp_sig == gold});
`endif
      end else if (k <= n) begin
        check("run_vld", {15'd0, stim_valid}, 16'd1);
        check("run_busy", {15'd0, busy}, 16'd1);
        check("run_done", {15'd0, done}, 16'd0);
        check("run_stim", {12'd0, stim}, {12'd0, e_stim[k-1]});
      end else begin
        check("flush_vld", {15'd0, stim_valid}, 16'd0);
        check("flush_busy", {15'd0, busy}, 16'd1);
        check("flush_done", {15'd0, done}, 16'd0);
        check("flush_stim", {12'd0, stim}, {12'd0, last_stim});
        if (flush_poke && k == n + 1) begin
          start   = 1'b1;
          seed    = 16'($urandom());
          num_pat = 16'($urandom_range(1, 9));
        end
      end
      if (k - PIPE_DEPTH >= 1 && k - PIPE_DEPTH <= n) resp = r_tab[k-PIPE_DEPTH-1];
      else                                            resp = pick_resp(mode);
      tick();
      start = 1'b0;
    end

    // The signature and the done level must hold while DONE persists.
    for (int h = 0; h < 2; h++) begin
      check("hold_sig", sig, exp_sig);
      check("hold_done", {15'd0, done}, 16'd1);
      resp = 1'($urandom());
      tick();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_stim"}, {12'd0, stim}, 16'd0);
    check({tag, "_vld"}, {15'd0, stim_valid}, 16'd0);
    check({tag, "_sig"}, sig, 16'h0000);
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_done"}, {15'd0, done}, 16'd0);
`ifdef STIM_MISR_GOLDEN_CMP_EN
    check({tag, "_pass"}, {15'd0, pass}, 16'd0);
`endif
  endtask

  initial begin
    // Power-on reset.
    tick();
    tick();
    check_reset_values("por");
    rst = 1'b0;

    // First edge after release with start high is accepted; stim 1,2,4,8,0.
    run_test(16'h0001, 5, 2, 1'b0, 16'h0000);

    // resp=0 throughout gives a zero signature; done at cycle 11.
    run_test(16'($urandom()), 8, 0, 1'b0, 16'h0000);
    check("zero_resp_sig", sig, 16'h0000);

    // resp=1 throughout.
    run_test(16'($urandom()), 2, 1, 1'b0, 16'h0000);
    check("ones2_sig", sig, 16'h0003);
    run_test(16'($urandom()), 1, 1, 1'b0, 16'h0000);
    check("ones1_sig", sig, 16'h0001);

    // Zero seed substitution, then an empty run.
    run_test(16'h0000, 1, 2, 1'b0, 16'h0000);
    run_test(16'($urandom()), 0, 1, 1'b0, 16'h0000);
    check("empty_sig", sig, 16'h0000);

    // A start pulse during FLUSH must be ignored.
    run_test(16'($urandom()), 6, 2, 1'b1, 16'h0000);

    // Randomized runs.
    for (int t = 0; t < 6; t++)
      run_test(16'($urandom()), int'($urandom_range(1, 24)), 2, 1'($urandom()), 16'($urandom()));
    run_test(16'($urandom()), 1000, 2, 1'b0, 16'h0000);

`ifdef STIM_MISR_GOLDEN_CMP_EN
    run_test(16'($urandom()), 2, 1, 1'b0, 16'h0003);
    check("golden_hit", {15'd0, pass}, 16'd1);
    run_test(16'($urandom()), 2, 1, 1'b0, 16'h0004);
    check("golden_miss", {15'd0, pass}, 16'd0);
`endif

    // Assert reset in the third RUN cycle. Outputs must clear within that same cycle.
    seed    = 16'($urandom());
    num_pat = 16'd10;
    start   = 1'b1;
    resp    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_pre_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    check_reset_values("abort");
    tick();
    rst = 1'b0;
    // No residual capture may occur in IDLE after the release.
    for (int i = 0; i < 4; i++) begin
      resp = 1'b1;
      tick();
      check_reset_values("idle_after_abort");
    end

    // Pulse reset again, then start on the very first edge after release.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_test(16'($urandom()), int'($urandom_range(1, 12)), 2, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
